// File: rtl/gactx_result_packer_if.sv
// Output beat stream of the GACT-X result packer: 512-bit ready/valid beats with a last flag.
// The master side drives data/valid/last; the slave side drives ready.
interface gactx_result_packer_if #(
   parameter int OUT_WIDTH = 512
);
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_last;

   modport master (output out_data, output out_valid, output out_last, input out_ready);
   modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/gactx_result_packer.sv
// Packs a GACT-X tile (header beat + direction words four per beat) into a 512-bit ready/valid stream.
// Optional trailer beat (cnt, collected, XOR of direction words) enabled by `define GACTX_PACKER_TRAILER_EN.
module gactx_result_packer #(
   parameter int DIR_WIDTH      = 128,
   parameter int OUT_WIDTH      = 512,
   parameter int FIFO_DEPTH     = 16,
   parameter int LOG_FIFO_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       done_in,
   input  logic [511:0]               tile_in,
   input  logic [31:0]                dir_count_in,
   input  logic [DIR_WIDTH-1:0]       dir_in,
   input  logic                       dir_valid_in,
   gactx_result_packer_if.master      out_if,
   output logic                       busy,
   output logic                       overflow,
   output logic                       protocol_err,
   output logic [31:0]                tiles_sent
);

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      PACK,
      EMIT
`ifdef GACTX_PACKER_TRAILER_EN
      , TRL
`endif
   } state_t;

   localparam logic [LOG_FIFO_DEPTH:0] PTR_ONE = 1;

   state_t state, next_state;

   logic [OUT_WIDTH-1:0]      hdr;
   logic [31:0]               cnt;
   logic [31:0]               collected;
   logic [2:0]                lane;
   logic [OUT_WIDTH-1:0]      lane_buf;

   logic [DIR_WIDTH-1:0]      fifo_mem [FIFO_DEPTH];
   logic [LOG_FIFO_DEPTH:0]   wr_ptr, rd_ptr;
   logic                      fifo_empty, fifo_full;
   logic [DIR_WIDTH-1:0]      fifo_head;
   logic                      pop, push_ok;

   logic [OUT_WIDTH-1:0]      out_data_c;
   logic                      out_valid_c, out_last_c;
   logic                      transfer;

`ifdef GACTX_PACKER_TRAILER_EN
   logic [DIR_WIDTH-1:0]      xor_acc;
   logic [OUT_WIDTH-1:0]      trailer_data;
`endif

   // Extra pointer bit distinguishes full from empty when the index bits match.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[LOG_FIFO_DEPTH] != rd_ptr[LOG_FIFO_DEPTH]) &&
                       (wr_ptr[LOG_FIFO_DEPTH-1:0] == rd_ptr[LOG_FIFO_DEPTH-1:0]);
   assign fifo_head  = fifo_mem[rd_ptr[LOG_FIFO_DEPTH-1:0]];
   assign pop        = (state == PACK) && !fifo_empty;
   assign push_ok    = dir_valid_in && (!fifo_full || pop);

   assign transfer   = out_valid_c && out_if.out_ready;
   assign busy       = (state != IDLE);

   assign out_if.out_data  = out_data_c;
   assign out_if.out_valid = out_valid_c;
   assign out_if.out_last  = out_last_c;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo_mem[wr_ptr[LOG_FIFO_DEPTH-1:0]] <= dir_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (dir_valid_in && fifo_full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (done_in) next_state = HDR;
         HDR: begin
            if (transfer) begin
               if (cnt != 32'd0) begin
                  next_state = PACK;
               end else begin
`ifdef GACTX_PACKER_TRAILER_EN
                  next_state = TRL;
`else
                  next_state = IDLE;
`endif
               end
            end
         end
         PACK: begin
            if (pop && ((lane == 3'd3) || (collected + 32'd1 == cnt))) begin
               next_state = EMIT;
            end
         end
         EMIT: begin
            if (transfer) begin
               if (collected != cnt) begin
                  next_state = PACK;
               end else begin
`ifdef GACTX_PACKER_TRAILER_EN
                  next_state = TRL;
`else
                  next_state = IDLE;
`endif
               end
            end
         end
`ifdef GACTX_PACKER_TRAILER_EN
         TRL: if (transfer) next_state = IDLE;
`endif
         default: next_state = IDLE;
      endcase
   end

`ifdef GACTX_PACKER_TRAILER_EN
   always_comb begin
      trailer_data                     = '0;
      trailer_data[31:0]               = cnt;
      trailer_data[63:32]              = collected;
      trailer_data[64 +: DIR_WIDTH]    = xor_acc;
   end
`endif

   // Outputs decode purely from registered state, so they hold steady under backpressure.
   always_comb begin
      out_data_c  = '0;
      out_valid_c = 1'b0;
      out_last_c  = 1'b0;
      case (state)
         HDR: begin
            out_data_c  = hdr;
            out_valid_c = 1'b1;
`ifndef GACTX_PACKER_TRAILER_EN
            out_last_c  = (cnt == 32'd0);
`endif
         end
         EMIT: begin
            out_data_c  = lane_buf;
            out_valid_c = 1'b1;
`ifndef GACTX_PACKER_TRAILER_EN
            out_last_c  = (collected == cnt);
`endif
         end
`ifdef GACTX_PACKER_TRAILER_EN
         TRL: begin
            out_data_c  = trailer_data;
            out_valid_c = 1'b1;
            out_last_c  = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hdr          <= '0;
         cnt          <= '0;
         collected    <= '0;
         lane         <= '0;
         lane_buf     <= '0;
         protocol_err <= 1'b0;
         tiles_sent   <= '0;
`ifdef GACTX_PACKER_TRAILER_EN
         xor_acc      <= '0;
`endif
      end else begin
         if ((state == IDLE) && done_in) begin
            hdr       <= tile_in;
            cnt       <= dir_count_in;
            collected <= '0;
            lane      <= '0;
            lane_buf  <= '0;
`ifdef GACTX_PACKER_TRAILER_EN
            xor_acc   <= '0;
`endif
         end
         if ((state != IDLE) && done_in) begin
            protocol_err <= 1'b1;
         end
         if (pop) begin
            for (int i = 0; i < 4; i++) begin
               if (lane[1:0] == 2'(i)) begin
                  lane_buf[i*DIR_WIDTH +: DIR_WIDTH] <= fifo_head;
               end
            end
            lane      <= lane + 3'd1;
            collected <= collected + 32'd1;
`ifdef GACTX_PACKER_TRAILER_EN
            xor_acc   <= xor_acc ^ fifo_head;
`endif
         end
         if ((state == EMIT) && transfer) begin
            lane     <= '0;
            lane_buf <= '0;
         end
         if (transfer && out_last_c) begin
            tiles_sent <= tiles_sent + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_gactx_result_packer.sv
// Scoreboard bench for gactx_result_packer: expected beats are queued as tiles are driven
// and popped by a monitor on each accepted beat; build with GACTX_PACKER_TRAILER_EN for the trailer variant.
module tb_gactx_result_packer;

   localparam int DW = 128;
   localparam int OW = 512;
`ifdef GACTX_PACKER_TRAILER_EN
   localparam bit TRL_EN = 1'b1;
`else
   localparam bit TRL_EN = 1'b0;
`endif

   typedef struct packed {
      logic [OW-1:0] data;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          done_in;
   logic [511:0]  tile_in;
   logic [31:0]   dir_count_in;
   logic [DW-1:0] dir_in;
   logic          dir_valid_in;
   logic          busy, overflow, protocol_err;
   logic [31:0]   tiles_sent;

   gactx_result_packer_if #(.OUT_WIDTH(OW)) out_if ();

   gactx_result_packer #(
      .DIR_WIDTH(DW), .OUT_WIDTH(OW), .FIFO_DEPTH(16), .LOG_FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst), .done_in(done_in), .tile_in(tile_in),
      .dir_count_in(dir_count_in), .dir_in(dir_in), .dir_valid_in(dir_valid_in),
      .out_if(out_if), .busy(busy), .overflow(overflow),
      .protocol_err(protocol_err), .tiles_sent(tiles_sent)
   );

   always #5 clk = ~clk;

   beat_t         exp_q[$];
   int            checks = 0;
   int            errors = 0;
   int            last_beats = 0;
   int            tiles_base = 0;
   logic [DW-1:0] word_mem [32];
   logic          held_valid = 1'b0;
   logic [OW-1:0] held_data;
   logic          held_last;

   task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Monitor: stall stability plus in-order scoreboard pop on every accepted beat.
   always @(negedge clk) begin
      if (rst) begin
         held_valid = 1'b0;
      end else begin
         if (held_valid) begin
            checkOutput("validHeld", out_if.out_valid, 1'b1);
            checkOutput("stallData", out_if.out_data, held_data);
            checkOutput("stallLast", out_if.out_last, held_last);
         end
         if (out_if.out_valid && out_if.out_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("beatQueue", 512'(exp_q.size()), 512'd1);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               checkOutput("beatData", out_if.out_data, e.data);
               checkOutput("beatLast", out_if.out_last, e.last);
               if (e.last) last_beats++;
            end
         end
         held_valid = out_if.out_valid && !out_if.out_ready;
         held_data  = out_if.out_data;
         held_last  = out_if.out_last;
      end
   end

   task automatic fillWords(input logic [DW-1:0] base);
      for (int k = 0; k < 32; k++) word_mem[k] = base + DW'(k);
   endtask

   task automatic pushBeats(input logic [511:0] tile, input int cnt, input int nwords);
      beat_t         b;
      logic [DW-1:0] x;
      int            nb;
      bit            complete;
      complete = (nwords == cnt);
      x        = '0;
      b.data   = tile;
      b.last   = (cnt == 0) && !TRL_EN;
      exp_q.push_back(b);
      nb = (nwords + 3) / 4;
      for (int bi = 0; bi < nb; bi++) begin
         b.data = '0;
         for (int l = 0; l < 4; l++) begin
            if (4*bi + l < nwords) begin
               b.data[l*DW +: DW] = word_mem[4*bi + l];
               x = x ^ word_mem[4*bi + l];
            end
         end
         b.last = (bi == nb - 1) && complete && !TRL_EN;
         exp_q.push_back(b);
      end
      if (TRL_EN && complete) begin
         b.data             = '0;
         b.data[31:0]       = 32'(cnt);
         b.data[63:32]      = 32'(cnt);
         b.data[64 +: DW]   = x;
         b.last             = 1'b1;
         exp_q.push_back(b);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_valid"}, out_if.out_valid, 1'b0);
      checkOutput({tag, "_last"}, out_if.out_last, 1'b0);
      checkOutput({tag, "_data"}, out_if.out_data, '0);
      checkOutput({tag, "_busy"}, busy, 1'b0);
      checkOutput({tag, "_overflow"}, overflow, 1'b0);
      checkOutput({tag, "_protoErr"}, protocol_err, 1'b0);
      checkOutput({tag, "_tiles"}, tiles_sent, '0);
   endtask

   // One-cycle reset pulse; outputs must be at reset values right after the edge.
   task automatic pulseReset(input string tag);
      rst = 1'b1;
      @(posedge clk); #1;
      exp_q.delete();
      tiles_base = last_beats;
      checkResetState(tag);
      rst = 1'b0;
   endtask

   task automatic applyStimulus(input logic [511:0] tile, input int cnt, input int gap,
                                input int first, input bit glitch, input bit rand_ready);
      int last_cycle;
      int n;
      pushBeats(tile, cnt, cnt);
      last_cycle = (cnt > 0) ? first + (cnt - 1) * gap : 0;
      for (int c = 0; c <= last_cycle + 1; c++) begin
         done_in      = (c == 0) || (glitch && cnt > 1 && c == first + gap);
         tile_in      = (c == 0) ? tile : ~tile;
         dir_count_in = (c == 0) ? 32'(cnt) : 32'hDEAD;
         dir_valid_in = 1'b0;
         if (c >= first && ((c - first) % gap) == 0 && ((c - first) / gap) < cnt) begin
            dir_valid_in = 1'b1;
            dir_in       = word_mem[(c - first) / gap];
         end
         if (rand_ready) out_if.out_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         if (c == 0) checkOutput("hdrLatency", out_if.out_valid, 1'b1);
      end
      done_in      = 1'b0;
      dir_valid_in = 1'b0;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 600) begin
         out_if.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); #1;
         n++;
      end
      out_if.out_ready = 1'b1;
      checkOutput("drain", 512'(exp_q.size()), 512'd0);
      checkOutput("idleAfterTile", busy, 1'b0);
      checkOutput("tilesSent", tiles_sent, 512'(last_beats - tiles_base));
   endtask

   initial begin
      int n;
      logic [511:0] tile;
      beat_t b;
      rst = 1'b1; done_in = 1'b0; tile_in = '0; dir_count_in = '0;
      dir_in = '0; dir_valid_in = 1'b0; out_if.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkResetState("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Header-only tile
      tile = {64{8'hA5}};
      applyStimulus(tile, 0, 1, 1, 1'b0, 1'b0);

      // Four words, spaced three cycles apart
      for (int k = 0; k < 4; k++) word_mem[k] = DW'(k + 1);
      applyStimulus({16{32'h1234_0001}}, 4, 3, 1, 1'b0, 1'b0);

      // Six words, first word in the same cycle as done_in
      fillWords(128'h10);
      applyStimulus({16{32'hCAFE_0006}}, 6, 1, 0, 1'b0, 1'b0);
      checkOutput("noProtoErr", protocol_err, 1'b0);

      // Random words under random backpressure
      for (int k = 0; k < 9; k++) word_mem[k] = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus({16{$urandom}}, 9, 2, 1, 1'b0, 1'b1);

      // done_in while packing is flagged and ignored
      fillWords(128'h40);
      applyStimulus({16{32'hBEEF_0004}}, 4, 3, 1, 1'b1, 1'b0);
      checkOutput("protoErr", protocol_err, 1'b1);

      // Stall in EMIT, then reset mid-tile
      fillWords(128'h100);
      tile = {16{32'h0E31_0004}};
      out_if.out_ready = 1'b0;
      b.data = tile; b.last = 1'b0;
      exp_q.push_back(b);
      done_in = 1'b1; tile_in = tile; dir_count_in = 32'd4;
      @(posedge clk); #1;
      done_in = 1'b0;
      for (int k = 0; k < 4; k++) begin
         dir_valid_in = 1'b1; dir_in = word_mem[k];
         @(posedge clk); #1;
      end
      dir_valid_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      out_if.out_ready = 1'b1;
      @(posedge clk); #1;
      out_if.out_ready = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("emitValid", out_if.out_valid, 1'b1);
      checkOutput("emitData", out_if.out_data, {word_mem[3], word_mem[2], word_mem[1], word_mem[0]});
      checkOutput("emitLast", out_if.out_last, !TRL_EN);
      checkOutput("emitQueue", 512'(exp_q.size()), 512'd0);
      pulseReset("midEmitReset");
      out_if.out_ready = 1'b1;

      // Overflow: 20 words into a 16-entry FIFO while the header is stalled
      fillWords(128'h200);
      tile = {16{32'h0F10_0020}};
      out_if.out_ready = 1'b0;
      pushBeats(tile, 20, 16);
      done_in = 1'b1; tile_in = tile; dir_count_in = 32'd20;
      @(posedge clk); #1;
      done_in = 1'b0;
      for (int k = 0; k < 20; k++) begin
         dir_valid_in = 1'b1; dir_in = word_mem[k];
         @(posedge clk); #1;
         if (k == 15) checkOutput("noOverflowAt16", overflow, 1'b0);
         if (k == 16) checkOutput("overflowAt17", overflow, 1'b1);
      end
      dir_valid_in = 1'b0;
      repeat (180) @(posedge clk);
      #1;
      checkOutput("stalledHdr", out_if.out_data, tile);
      out_if.out_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      checkOutput("ovfDrain", 512'(exp_q.size()), 512'd0);
      checkOutput("ovfStillBusy", busy, 1'b1);
      checkOutput("ovfSticky", overflow, 1'b1);
      checkOutput("ovfTiles", tiles_sent, 512'(last_beats - tiles_base));
      pulseReset("ovfReset");

      // Two words whose XOR fills the low byte
      word_mem[0] = 128'hF0;
      word_mem[1] = 128'h0F;
      applyStimulus({16{32'h7777_0002}}, 2, 2, 1, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
